// File: rtl/selecionar_ativo.sv
// selecionar_ativo: requests a classifier update, latches the minimum criterion it
// returns, then scans the active-node slots one per cycle for the lowest-index
// active slot whose criterion equals that minimum. The result is offered with a
// valid/accept handshake.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// OCIOSO      | idle, waiting for sa_iniciar_in
// CLASSIFICAR | update pulse on sa_atualizar_o, wait counter cleared
// AGUARDAR    | waiting for ca_pronto_in, bounded by ESPERA_MAX cycles
// BUSCAR      | examines slot r_busca each cycle, lowest hit wins
// ENTREGAR    | result valid and held until sa_aceito_in
module selecionar_ativo #(
   parameter int NUM_NA         = 8,
   parameter int CRITERIO_WIDTH = 5,
   parameter int ESPERA_MAX     = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 sa_iniciar_in,
   input  logic [NUM_NA-1:0]                    na_ativo_in,
   input  logic [NUM_NA*CRITERIO_WIDTH-1:0]     na_criterio_in,
   input  logic                                 ca_pronto_in,
   input  logic [CRITERIO_WIDTH-1:0]            ca_criterio_geral_in,
   output logic                                 sa_atualizar_o,
   output logic                                 sa_ocupado_o,
   output logic                                 sa_valido_o,
   output logic [$clog2(NUM_NA)-1:0]            sa_indice_o,
   output logic [NUM_NA-1:0]                    sa_onehot_o,
   output logic                                 sa_vazio_o,
   output logic                                 sa_erro_o,
   input  logic                                 sa_aceito_in
);

   localparam int IW = $clog2(NUM_NA);
   localparam int EW = $clog2(ESPERA_MAX);
   localparam int CW = CRITERIO_WIDTH;

   // Terminal-count values sized to their counters so the compares are exact.
   localparam logic [IW-1:0] BUSCA_ULT  = IW'(NUM_NA - 1);
   localparam logic [EW-1:0] ESPERA_ULT = EW'(ESPERA_MAX - 1);

   typedef enum logic [2:0] {
      OCIOSO,
      CLASSIFICAR,
      AGUARDAR,
      BUSCAR,
      ENTREGAR
   } estado_t;

   estado_t                r_estado;
   estado_t                w_prox;

   logic                   r_atualizar;
   logic                   r_ocupado;
   logic                   r_valido;
   logic [IW-1:0]          r_indice;
   logic [NUM_NA-1:0]      r_onehot;
   logic                   r_vazio;
   logic                   r_erro;
   logic [CW-1:0]          r_criterio;
   logic [IW-1:0]          r_busca;
   logic [EW-1:0]          r_espera;

   logic                   w_atualizar;
   logic                   w_ocupado;
   logic                   w_valido;
   logic [IW-1:0]          w_indice;
   logic [NUM_NA-1:0]      w_onehot;
   logic                   w_vazio;
   logic                   w_erro;
   logic [CW-1:0]          w_criterio;
   logic [IW-1:0]          w_busca;
   logic [EW-1:0]          w_espera;

   logic [CW-1:0]          w_crit_slot;
   logic                   w_acerto;
   logic [NUM_NA-1:0]      w_sel;

   // Slot currently under examination: hit test and its one-hot encoding.
   always_comb begin
      w_crit_slot = na_criterio_in[r_busca*CW +: CW];
      w_acerto    = na_ativo_in[r_busca] && (w_crit_slot == r_criterio);
      w_sel       = '0;
      w_sel[r_busca] = 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_prox;
      end
   end

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      w_prox      = r_estado;
      w_atualizar = 1'b0;
      w_valido    = r_valido;
      w_indice    = r_indice;
      w_onehot    = r_onehot;
      w_vazio     = r_vazio;
      w_erro      = r_erro;
      w_criterio  = r_criterio;
      w_busca     = r_busca;
      w_espera    = r_espera;

      case (r_estado)
         OCIOSO: begin
            if (sa_iniciar_in) begin
               w_prox      = CLASSIFICAR;
               w_atualizar = 1'b1;
            end
         end

         CLASSIFICAR: begin
            w_espera = '0;
            w_prox   = AGUARDAR;
         end

         AGUARDAR: begin
            w_espera = r_espera + 1'b1;
            if (ca_pronto_in) begin
               w_criterio = ca_criterio_geral_in;
               w_busca    = '0;
               w_prox     = BUSCAR;
            end else if (r_espera == ESPERA_ULT) begin
               w_prox   = ENTREGAR;
               w_valido = 1'b1;
               w_erro   = 1'b1;
               w_vazio  = 1'b0;
               w_indice = '0;
               w_onehot = '0;
            end
         end

         BUSCAR: begin
            if (w_acerto) begin
               w_prox   = ENTREGAR;
               w_valido = 1'b1;
               w_indice = r_busca;
               w_onehot = w_sel;
               w_vazio  = 1'b0;
               w_erro   = 1'b0;
            end else if (r_busca == BUSCA_ULT) begin
               // Stop at the last real slot; never wrap, even when NUM_NA
               // is not a power of two.
               w_prox   = ENTREGAR;
               w_valido = 1'b1;
               w_indice = '0;
               w_onehot = '0;
               w_vazio  = 1'b1;
               w_erro   = 1'b0;
            end else begin
               w_busca = r_busca + 1'b1;
            end
         end

         ENTREGAR: begin
            if (sa_aceito_in) begin
               // sa_indice_o deliberately keeps its last value.
               w_prox   = OCIOSO;
               w_valido = 1'b0;
               w_erro   = 1'b0;
               w_vazio  = 1'b0;
               w_onehot = '0;
            end
         end

         default: begin
            w_prox = OCIOSO;
         end
      endcase

      w_ocupado = (w_prox != OCIOSO);
   end

   // Registered outputs, latched criterion and the two counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_atualizar <= 1'b0;
         r_ocupado   <= 1'b0;
         r_valido    <= 1'b0;
         r_indice    <= '0;
         r_onehot    <= '0;
         r_vazio     <= 1'b0;
         r_erro      <= 1'b0;
         r_criterio  <= '0;
         r_busca     <= '0;
         r_espera    <= '0;
      end else begin
         r_atualizar <= w_atualizar;
         r_ocupado   <= w_ocupado;
         r_valido    <= w_valido;
         r_indice    <= w_indice;
         r_onehot    <= w_onehot;
         r_vazio     <= w_vazio;
         r_erro      <= w_erro;
         r_criterio  <= w_criterio;
         r_busca     <= w_busca;
         r_espera    <= w_espera;
      end
   end

   assign sa_atualizar_o = r_atualizar;
   assign sa_ocupado_o   = r_ocupado;
   assign sa_valido_o    = r_valido;
   assign sa_indice_o    = r_indice;
   assign sa_onehot_o    = r_onehot;
   assign sa_vazio_o     = r_vazio;
   assign sa_erro_o      = r_erro;

endmodule

// File: tb/tb_selecionar_ativo.sv
// Bench for selecionar_ativo: directed scenarios plus randomized slot vectors,
// checked against a plain search model of the lowest-index matching slot.
module tb_selecionar_ativo;

   localparam int NUM_NA = 8;
   localparam int CW     = 5;
   localparam int ESPERA = 32;
   localparam int IW     = $clog2(NUM_NA);

   logic                    clk;
   logic                    rst_n;
   logic                    sa_iniciar_in;
   logic [NUM_NA-1:0]       na_ativo_in;
   logic [NUM_NA*CW-1:0]    na_criterio_in;
   logic                    ca_pronto_in;
   logic [CW-1:0]           ca_criterio_geral_in;
   logic                    sa_atualizar_o;
   logic                    sa_ocupado_o;
   logic                    sa_valido_o;
   logic [IW-1:0]           sa_indice_o;
   logic [NUM_NA-1:0]       sa_onehot_o;
   logic                    sa_vazio_o;
   logic                    sa_erro_o;
   logic                    sa_aceito_in;

   int n_pass  = 0;
   int n_total = 0;
   int n_upd   = 0;

   selecionar_ativo #(
      .NUM_NA(NUM_NA), .CRITERIO_WIDTH(CW), .ESPERA_MAX(ESPERA)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .sa_iniciar_in(sa_iniciar_in),
      .na_ativo_in(na_ativo_in),
      .na_criterio_in(na_criterio_in),
      .ca_pronto_in(ca_pronto_in),
      .ca_criterio_geral_in(ca_criterio_geral_in),
      .sa_atualizar_o(sa_atualizar_o),
      .sa_ocupado_o(sa_ocupado_o),
      .sa_valido_o(sa_valido_o),
      .sa_indice_o(sa_indice_o),
      .sa_onehot_o(sa_onehot_o),
      .sa_vazio_o(sa_vazio_o),
      .sa_erro_o(sa_erro_o),
      .sa_aceito_in(sa_aceito_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles in which the update pulse is high.
   always @(posedge clk) if (sa_atualizar_o) n_upd++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: lowest-index active slot whose criterion equals the minimum.
   function automatic void model(input logic [NUM_NA-1:0] at, input logic [NUM_NA*CW-1:0] cr,
                                 input logic [CW-1:0] g, output bit hit, output int idx);
      hit = 0;
      idx = 0;
      for (int i = 0; i < NUM_NA; i++) begin
         if (!hit && at[i] && (cr[i*CW +: CW] == g)) begin
            hit = 1;
            idx = i;
         end
      end
   endfunction

   // Start, let the classifier answer d cycles into AGUARDAR with g, and
   // report cycles from BUSCAR entry until valid (-1 if it never came).
   task automatic do_txn(input logic [CW-1:0] g, input int d, output int lat, output int upd);
      int u0;
      u0 = n_upd;
      sa_iniciar_in = 1'b1;
      tick();
      sa_iniciar_in = 1'b0;
      for (int i = 0; i < d; i++) tick();
      ca_pronto_in = 1'b1;
      ca_criterio_geral_in = g;
      tick();
      ca_pronto_in = 1'b0;
      ca_criterio_geral_in = $urandom;
      lat = 0;
      while (!sa_valido_o && lat < 200) begin
         tick();
         lat++;
      end
      if (!sa_valido_o) lat = -1;
      upd = n_upd - u0;
   endtask

   task automatic accept();
      sa_aceito_in = 1'b1;
      tick();
      sa_aceito_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_total++;
      if ({sa_atualizar_o, sa_ocupado_o, sa_valido_o, sa_indice_o, sa_onehot_o, sa_vazio_o, sa_erro_o} !== '0)
         $display("FAIL reset_outputs: got %0h %0h %0h %0h %0h %0h %0h expected all 0",
                  sa_atualizar_o, sa_ocupado_o, sa_valido_o, sa_indice_o, sa_onehot_o, sa_vazio_o, sa_erro_o);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      tick();
      n_total++;
      if (sa_ocupado_o !== 1'b0) $display("FAIL reset_idle: ocupado got %0b expected 0", sa_ocupado_o);
      else n_pass++;
   endtask

   task automatic test_basic();
      int lat, upd;
      na_ativo_in = '0;
      for (int i = 0; i < NUM_NA; i++) na_criterio_in[i*CW +: CW] = CW'($urandom);
      na_ativo_in[2] = 1'b1; na_criterio_in[2*CW +: CW] = 5'd9;
      na_ativo_in[5] = 1'b1; na_criterio_in[5*CW +: CW] = 5'd3;
      na_ativo_in[6] = 1'b1; na_criterio_in[6*CW +: CW] = 5'd7;
      do_txn(5'd3, 2, lat, upd);
      n_total++;
      if (upd !== 1) $display("FAIL basic_atualizar_count: got %0d expected 1", upd);
      else n_pass++;
      n_total++;
      if (lat !== 6) $display("FAIL basic_latency: got %0d expected 6", lat);
      else n_pass++;
      n_total++;
      if (sa_indice_o !== 3'd5 || sa_onehot_o !== 8'h20 || sa_vazio_o !== 1'b0 || sa_erro_o !== 1'b0)
         $display("FAIL basic_result: got idx=%0d oh=%0h vazio=%0b erro=%0b expected idx=5 oh=20 vazio=0 erro=0",
                  sa_indice_o, sa_onehot_o, sa_vazio_o, sa_erro_o);
      else n_pass++;
      n_total++;
      if (sa_ocupado_o !== 1'b1) $display("FAIL basic_ocupado: got %0b expected 1", sa_ocupado_o);
      else n_pass++;
      accept();
      n_total++;
      if (sa_valido_o !== 1'b0 || sa_onehot_o !== '0 || sa_ocupado_o !== 1'b0 || sa_indice_o !== 3'd5)
         $display("FAIL basic_after_accept: got valido=%0b oh=%0h ocupado=%0b idx=%0d expected 0 0 0 5",
                  sa_valido_o, sa_onehot_o, sa_ocupado_o, sa_indice_o);
      else n_pass++;
   endtask

   task automatic test_tie();
      int lat, upd;
      na_ativo_in = '0;
      na_ativo_in[1] = 1'b1; na_criterio_in[1*CW +: CW] = 5'd3;
      na_ativo_in[4] = 1'b1; na_criterio_in[4*CW +: CW] = 5'd3;
      do_txn(5'd3, 1, lat, upd);
      n_total++;
      if (sa_indice_o !== 3'd1 || sa_onehot_o !== 8'h02 || lat !== 2)
         $display("FAIL tie: got idx=%0d oh=%0h lat=%0d expected idx=1 oh=02 lat=2", sa_indice_o, sa_onehot_o, lat);
      else n_pass++;
      accept();
   endtask

   task automatic test_boundary();
      int lat, upd;
      na_ativo_in = '0;
      do_txn(5'h1F, 3, lat, upd);
      n_total++;
      if (sa_vazio_o !== 1'b1 || sa_onehot_o !== '0 || sa_indice_o !== '0 || sa_erro_o !== 1'b0 || lat !== NUM_NA)
         $display("FAIL empty: got vazio=%0b oh=%0h idx=%0d erro=%0b lat=%0d expected 1 0 0 0 %0d",
                  sa_vazio_o, sa_onehot_o, sa_indice_o, sa_erro_o, lat, NUM_NA);
      else n_pass++;
      accept();
      na_ativo_in[7] = 1'b1;
      na_criterio_in[7*CW +: CW] = 5'h1F;
      do_txn(5'h1F, 1, lat, upd);
      n_total++;
      if (sa_vazio_o !== 1'b0 || sa_indice_o !== 3'd7 || sa_onehot_o !== 8'h80 || lat !== NUM_NA)
         $display("FAIL last_slot: got vazio=%0b idx=%0d oh=%0h lat=%0d expected 0 7 80 %0d",
                  sa_vazio_o, sa_indice_o, sa_onehot_o, lat, NUM_NA);
      else n_pass++;
      accept();
   endtask

   task automatic test_timeout();
      int cnt, u0;
      na_ativo_in = 8'hFF;
      u0 = n_upd;
      sa_iniciar_in = 1'b1;
      tick();
      sa_iniciar_in = 1'b0;
      // Now in CLASSIFICAR. AGUARDAR lasts ESPERA_MAX cycles after it.
      cnt = 0;
      while (!sa_valido_o && cnt < 200) begin
         tick();
         cnt++;
      end
      n_total++;
      if (cnt !== ESPERA + 1) $display("FAIL timeout_latency: got %0d expected %0d", cnt, ESPERA + 1);
      else n_pass++;
      n_total++;
      if (sa_erro_o !== 1'b1 || sa_vazio_o !== 1'b0 || sa_onehot_o !== '0 || sa_indice_o !== '0)
         $display("FAIL timeout_result: got erro=%0b vazio=%0b oh=%0h idx=%0d expected 1 0 0 0",
                  sa_erro_o, sa_vazio_o, sa_onehot_o, sa_indice_o);
      else n_pass++;
      ca_pronto_in = 1'b1;
      ca_criterio_geral_in = '0;
      tick();
      ca_pronto_in = 1'b0;
      tick();
      n_total++;
      if (sa_valido_o !== 1'b1 || sa_erro_o !== 1'b1 || sa_onehot_o !== '0)
         $display("FAIL late_pronto: got valido=%0b erro=%0b oh=%0h expected 1 1 0", sa_valido_o, sa_erro_o, sa_onehot_o);
      else n_pass++;
      accept();
      n_total++;
      if (sa_erro_o !== 1'b0 || sa_valido_o !== 1'b0)
         $display("FAIL timeout_clear: got erro=%0b valido=%0b expected 0 0", sa_erro_o, sa_valido_o);
      else n_pass++;
      ca_pronto_in = 1'b1;
      tick();
      ca_pronto_in = 1'b0;
      tick();
      n_total++;
      if (sa_ocupado_o !== 1'b0 || (n_upd - u0) !== 1)
         $display("FAIL idle_pronto: got ocupado=%0b updates=%0d expected 0 1", sa_ocupado_o, n_upd - u0);
      else n_pass++;
   endtask

   task automatic test_random();
      int lat, upd, idx, errs;
      bit hit;
      logic [CW-1:0] g;
      logic [NUM_NA-1:0] e_oh;
      for (int t = 0; t < 25; t++) begin
         na_ativo_in = NUM_NA'($urandom);
         for (int i = 0; i < NUM_NA; i++) na_criterio_in[i*CW +: CW] = CW'($urandom_range(0, 3));
         g = CW'($urandom_range(0, 3));
         model(na_ativo_in, na_criterio_in, g, hit, idx);
         e_oh = '0;
         if (hit) e_oh[idx] = 1'b1;
         do_txn(g, $urandom_range(1, 6), lat, upd);
         errs = 0;
         if (sa_indice_o !== (hit ? IW'(idx) : IW'(0))) errs++;
         if (sa_onehot_o !== e_oh) errs++;
         if (sa_vazio_o !== !hit) errs++;
         if (sa_erro_o !== 1'b0) errs++;
         if (lat !== (hit ? idx + 1 : NUM_NA)) errs++;
         if (upd !== 1) errs++;
         n_total++;
         if (errs != 0)
            $display("FAIL random_%0d: got idx=%0d oh=%0h vazio=%0b erro=%0b lat=%0d upd=%0d expected hit=%0b idx=%0d oh=%0h lat=%0d upd=1",
                     t, sa_indice_o, sa_onehot_o, sa_vazio_o, sa_erro_o, lat, upd,
                     hit, idx, e_oh, hit ? idx + 1 : NUM_NA);
         else n_pass++;
         accept();
      end
   endtask

   task automatic test_back_to_back();
      int lat, upd, u0, unstable;
      na_ativo_in = '0;
      na_ativo_in[3] = 1'b1;
      na_criterio_in[3*CW +: CW] = 5'd12;
      u0 = n_upd;
      do_txn(5'd12, 2, lat, upd);
      sa_iniciar_in = 1'b1;
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sa_valido_o !== 1'b1 || sa_indice_o !== 3'd3 || sa_onehot_o !== 8'h08 || sa_vazio_o !== 1'b0)
            unstable++;
      end
      n_total++;
      if (unstable != 0) $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", unstable);
      else n_pass++;
      sa_aceito_in = 1'b1;
      tick();
      sa_aceito_in = 1'b0;
      sa_iniciar_in = 1'b0;
      n_total++;
      if (sa_ocupado_o !== 1'b0 || sa_valido_o !== 1'b0 || (n_upd - u0) !== 1)
         $display("FAIL busy_start_ignored: got ocupado=%0b valido=%0b updates=%0d expected 0 0 1",
                  sa_ocupado_o, sa_valido_o, n_upd - u0);
      else n_pass++;
      tick();
      n_total++;
      if (sa_atualizar_o !== 1'b0 || sa_ocupado_o !== 1'b0)
         $display("FAIL accept_cycle_start: got atualizar=%0b ocupado=%0b expected 0 0", sa_atualizar_o, sa_ocupado_o);
      else n_pass++;
      do_txn(5'd12, 1, lat, upd);
      n_total++;
      if (sa_indice_o !== 3'd3 || lat !== 4 || upd !== 1)
         $display("FAIL restart: got idx=%0d lat=%0d upd=%0d expected 3 4 1", sa_indice_o, lat, upd);
      else n_pass++;
      accept();
   endtask

   task automatic test_reset_mid();
      int lat, upd, u0;
      na_ativo_in = '0;
      na_ativo_in[0] = 1'b1;
      na_criterio_in[CW-1:0] = 5'd4;
      sa_iniciar_in = 1'b1;
      tick();
      sa_iniciar_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({sa_atualizar_o, sa_ocupado_o, sa_valido_o, sa_indice_o, sa_onehot_o, sa_vazio_o, sa_erro_o} !== '0)
         $display("FAIL reset_aguardar: got ocupado=%0b valido=%0b expected all outputs 0", sa_ocupado_o, sa_valido_o);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      u0 = n_upd;
      ca_pronto_in = 1'b1;
      tick();
      ca_pronto_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_total++;
      if (sa_ocupado_o !== 1'b0 || sa_valido_o !== 1'b0 || (n_upd - u0) !== 0)
         $display("FAIL post_reset_idle: got ocupado=%0b valido=%0b updates=%0d expected 0 0 0",
                  sa_ocupado_o, sa_valido_o, n_upd - u0);
      else n_pass++;
      na_ativo_in[2] = 1'b1;
      na_criterio_in[2*CW +: CW] = 5'd6;
      do_txn(5'd6, 1, lat, upd);
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({sa_atualizar_o, sa_ocupado_o, sa_valido_o, sa_indice_o, sa_onehot_o, sa_vazio_o, sa_erro_o} !== '0)
         $display("FAIL reset_entregar: got valido=%0b idx=%0d oh=%0h expected all outputs 0",
                  sa_valido_o, sa_indice_o, sa_onehot_o);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      n_total++;
      if (sa_ocupado_o !== 1'b0 || sa_valido_o !== 1'b0)
         $display("FAIL post_reset_entregar: got ocupado=%0b valido=%0b expected 0 0", sa_ocupado_o, sa_valido_o);
      else n_pass++;
   endtask

   initial begin
      rst_n                = 1'b0;
      sa_iniciar_in        = 1'b0;
      na_ativo_in          = '0;
      na_criterio_in       = '0;
      ca_pronto_in         = 1'b0;
      ca_criterio_geral_in = '0;
      sa_aceito_in         = 1'b0;
      #3;
      test_reset();
      test_basic();
      test_tie();
      test_boundary();
      test_timeout();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
